// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: aluop encodings and the mul/div sequencer states.
package pipeline_pkg;

    localparam logic [5:0] NOP_OP  = 6'b000000;
    localparam logic [5:0] MULT_OP = 6'b000010;
    localparam logic [5:0] DIV_OP  = 6'b000011;
    localparam logic [5:0] MFHI_OP = 6'b000100;
    localparam logic [5:0] MFLO_OP = 6'b000101;
    localparam logic [5:0] LW      = 6'b100011;
    localparam logic [5:0] SW      = 6'b101011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the unsigned magnitude datapath: a shift-add multiply step
// or a restoring divide step, selected by the operation kind.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc_in,
    input  logic [WIDTH-1:0]   rem_in,
    input  logic [WIDTH-1:0]   a_mag,
    input  logic [WIDTH-1:0]   b_mag,
    input  logic               mul_bit,
    input  logic               div_bit,
    output logic [2*WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0]   rem_out
);

    logic [WIDTH-1:0] addend;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic [WIDTH:0]   div_trial;
    logic             q_bit;

    // Multiply adds the multiplicand into the upper half and shifts the product
    // right; divide shifts the next dividend bit into a WIDTH+1 bit trial
    // remainder and keeps the difference only when it did not go negative.
    always_comb begin
        addend    = mul_bit ? a_mag : '0;
        mul_sum   = {1'b0, acc_in[2*WIDTH-1:WIDTH]} + {1'b0, addend};
        div_shift = {rem_in, div_bit};
        div_trial = div_shift - {1'b0, b_mag};
        q_bit     = ~div_trial[WIDTH];
        if (is_div) begin
            acc_out = {acc_in[2*WIDTH-1:WIDTH], acc_in[WIDTH-2:0], q_bit};
            rem_out = q_bit ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
        end else begin
            acc_out = {mul_sum, acc_in[WIDTH-1:1]};
            rem_out = rem_in;
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle signed multiply/divide unit with architectural HI/LO, stall
// generation toward fetch/decode and the MFHI/MFLO read path.
module muldiv_unit
    import pipeline_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             issue_valid,
    input  logic [5:0]       issue_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             abort,
    output logic             busy,
    output logic             stall,
    output logic [WIDTH-1:0] mf_result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   a_mag_q, a_mag_d;
    logic [WIDTH-1:0]   b_mag_q, b_mag_d;
    logic               sign_a_q, sign_a_d;
    logic               sign_b_q, sign_b_d;
    logic               is_div_q, is_div_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;

    logic               is_muldiv;
    logic               is_mf;
    logic               accept;
    logic [2*WIDTH-1:0] step_acc;
    logic [WIDTH-1:0]   step_rem;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quot_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   a_orig;

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div  (is_div_q),
        .acc_in  (acc_q),
        .rem_in  (rem_q),
        .a_mag   (a_mag_q),
        .b_mag   (b_mag_q),
        .mul_bit (b_mag_q[cnt_q]),
        .div_bit (a_mag_q[LAST_CNT - cnt_q]),
        .acc_out (step_acc),
        .rem_out (step_rem)
    );

    // Decode, hazard detection and the MFHI/MFLO result mux; busy comes straight
    // from the state register so any younger HI/LO user stalls while in flight.
    always_comb begin
        is_muldiv = (issue_op == MULT_OP) || (issue_op == DIV_OP);
        is_mf     = (issue_op == MFHI_OP) || (issue_op == MFLO_OP);
        busy      = (state_q != IDLE);
        accept    = issue_valid && !busy && !abort && is_muldiv;
        stall     = issue_valid && busy && (is_muldiv || is_mf);
        mf_result = '0;
        if (issue_op == MFHI_OP) begin
            mf_result = hi_q;
        end else if (issue_op == MFLO_OP) begin
            mf_result = lo_q;
        end
        hi = hi_q;
        lo = lo_q;
    end

    // Sign fix-up of the magnitude results; the remainder follows the dividend.
    always_comb begin
        prod_fix = (sign_a_q ^ sign_b_q) ? -acc_q : acc_q;
        quot_fix = (sign_a_q ^ sign_b_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = sign_a_q ? -rem_q : rem_q;
        a_orig   = sign_a_q ? -a_mag_q : a_mag_q;
    end

    // Sequencer: accept into RUN, iterate WIDTH times, write HI/LO in FIX unless
    // squashed; abort always wins and drops the partial result.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        a_mag_d  = a_mag_q;
        b_mag_d  = b_mag_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    sign_a_d = op_a[WIDTH-1];
                    sign_b_d = op_b[WIDTH-1];
                    a_mag_d  = op_a[WIDTH-1] ? -op_a : op_a;
                    b_mag_d  = op_b[WIDTH-1] ? -op_b : op_b;
                    is_div_d = (issue_op == DIV_OP);
                    cnt_d    = '0;
                    acc_d    = '0;
                    rem_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else begin
                    acc_d = step_acc;
                    rem_d = step_rem;
                    if (cnt_q == LAST_CNT) begin
                        cnt_d   = '0;
                        state_d = FIX;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            FIX: begin
                state_d = IDLE;
                if (!abort) begin
                    if (!is_div_q) begin
                        {hi_d, lo_d} = prod_fix;
                    end else if (b_mag_q == '0) begin
                        hi_d = a_orig;
                        lo_d = '1;
                    end else begin
                        hi_d = rem_fix;
                        lo_d = quot_fix;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, cleared asynchronously by reset_n.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            a_mag_q  <= a_mag_d;
            b_mag_q  <= b_mag_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
        end
    end

endmodule
